planet_emp_snd_arb: RTL and testbench

Sound scheduler for the Planet Empire core: shares the single piezo output between several sound sources (missile fly, empire hit, game over) by fixed-priority arbitration with preemption. Each source is granted through a request/acknowledge handshake and plays a square tone of parameter-defined pitch and duration, timed by the core's 1 us prescaler enable. The block replaces the direct `SOUND_o` toggle divider in `PLANET_EMP_CORE` and drives `SOUND_o` from the arbitrated tone.

---
 rtl/planet_emp_snd_arb_pkg.sv | 23 ++
 rtl/planet_emp_snd_arb_tick_ctr.sv | 40 ++++
 rtl/planet_emp_snd_arb.sv | 204 ++++++++++++++++++++
 tb/tb_planet_emp_snd_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/planet_emp_snd_arb_pkg.sv
// Planet Empire sound arbiter: shared state codes and default tone table.
// The debug-accelerated table shortens tones for fast bring-up runs.
package planet_emp_snd_arb_pkg;

  typedef logic [1:0] snd_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam bit C_DBG_ACC = 1'b0;

  localparam logic [35:0] C_HALF_DEF = C_DBG_ACC ?
    {12'd10, 12'd4, 12'd2} :
    {12'd1000, 12'd400, 12'd150};

  localparam logic [65:0] C_DUR_DEF = C_DBG_ACC ?
    {22'd2_000, 22'd500, 22'd300} :
    {22'd2_000_000, 22'd500_000, 22'd300_000};

  localparam int unsigned C_GAP_DEF = C_DBG_ACC ? 10 : 1000;

endpackage

// File: rtl/planet_emp_snd_arb_tick_ctr.sv
// Clearable tick counter: counts EE_i pulses and wraps at TERM_i.
// TC_o flags the tick that lands on the terminal value.
module SND_TICK_CTR
  import planet_emp_snd_arb_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic         CK_i,
  input  logic         XARST_i,
  input  logic         CLR_i,
  input  logic         EE_i,
  input  logic [W-1:0] TERM_i,
  output logic         TC_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         hit;

  assign hit  = (cnt_q == TERM_i);
  assign TC_o = EE_i & ~CLR_i & hit;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR_i) begin
      cnt_d = '0;
    end else if (EE_i) begin
      cnt_d = hit ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/planet_emp_snd_arb.sv
// Fixed-priority, preemptive sound arbiter driving the shared piezo.
// Highest requester index wins; each grant plays one timed square tone.
module planet_emp_snd_arb
  import planet_emp_snd_arb_pkg::*;
#(
  parameter int unsigned C_REQ_N  = 3,
  parameter int unsigned C_HALF_W = 12,
  parameter int unsigned C_DUR_W  = 22,
  parameter logic [C_REQ_N*C_HALF_W-1:0] C_HALF_Ns = C_HALF_DEF,
  parameter logic [C_REQ_N*C_DUR_W-1:0]  C_DUR_Ns  = C_DUR_DEF,
  parameter int unsigned C_GAP_N  = C_GAP_DEF
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               EE_i,
  input  logic               RST_i,
  input  logic [C_REQ_N-1:0] REQs_i,
  output logic [C_REQ_N-1:0] ACKs_o,
  output logic [C_REQ_N-1:0] GNTs_o,
  output logic [C_REQ_N-1:0] DONEs_o,
  output logic [C_REQ_N-1:0] DROPs_o,
  output logic               BUSY_o,
  output logic               SOUND_o
);

  localparam int unsigned IDX_W =
    (C_REQ_N > 1) ? $clog2(C_REQ_N) : 1;
  localparam int unsigned GAP_W = $clog2(C_GAP_N + 1);

  snd_state_t state_q, state_d;
  logic [IDX_W-1:0] own_q, own_d;
  logic [C_REQ_N-1:0] ack_q, ack_d;
  logic [C_REQ_N-1:0] gnt_q, gnt_d;
  logic [C_REQ_N-1:0] done_q, done_d;
  logic [C_REQ_N-1:0] drop_q, drop_d;
  logic busy_q, busy_d;
  logic sound_q, sound_d;

  logic             hi_vld;
  logic [IDX_W-1:0] hi_idx;
  logic             preempt;
  logic [C_HALF_W-1:0] half_fld;
  logic [C_DUR_W-1:0]  dur_fld;
  logic half_tc, dur_tc, gap_tc;
  logic clr_play, clr_gap;

  function automatic logic [C_REQ_N-1:0] oh(
    input logic [IDX_W-1:0] idx
  );
    logic [C_REQ_N-1:0] r;
    for (int i = 0; i < C_REQ_N; i++) begin
      r[i] = (idx == IDX_W'(i));
    end
    return r;
  endfunction

  // Ascending scan so the highest set index is the one kept.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = 0; i < C_REQ_N; i++) begin
      if (REQs_i[i]) begin
        hi_vld = 1'b1;
        hi_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    half_fld = '0;
    dur_fld  = '0;
    for (int i = 0; i < C_REQ_N; i++) begin
      if (own_q == IDX_W'(i)) begin
        half_fld = C_HALF_Ns[i*C_HALF_W +: C_HALF_W];
        dur_fld  = C_DUR_Ns[i*C_DUR_W +: C_DUR_W];
      end
    end
  end

  assign preempt = (state_q == S_PLAY) & hi_vld
                 & (hi_idx > own_q);

  assign clr_play = RST_i | (state_q != S_PLAY)
                  | preempt;
  assign clr_gap  = RST_i | (state_q != S_GAP);

  SND_TICK_CTR #(.W(C_HALF_W)) u_half (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .CLR_i   (clr_play),
    .EE_i    (EE_i),
    .TERM_i  (half_fld - C_HALF_W'(1)),
    .TC_o    (half_tc)
  );

  SND_TICK_CTR #(.W(C_DUR_W)) u_dur (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .CLR_i   (clr_play),
    .EE_i    (EE_i),
    .TERM_i  (dur_fld - C_DUR_W'(1)),
    .TC_o    (dur_tc)
  );

  SND_TICK_CTR #(.W(GAP_W)) u_gap (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .CLR_i   (clr_gap),
    .EE_i    (EE_i),
    .TERM_i  (GAP_W'(C_GAP_N - 1)),
    .TC_o    (gap_tc)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ack_d   = '0;
    done_d  = '0;
    drop_d  = '0;
    gnt_d   = gnt_q;
    sound_d = sound_q;
    unique case (state_q)
      S_IDLE: begin
        sound_d = 1'b0;
        gnt_d   = '0;
        if (hi_vld) begin
          ack_d   = oh(hi_idx);
          gnt_d   = oh(hi_idx);
          own_d   = hi_idx;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Preemption outranks completion in the same cycle.
        if (preempt) begin
          drop_d  = oh(own_q);
          ack_d   = oh(hi_idx);
          gnt_d   = oh(hi_idx);
          own_d   = hi_idx;
          sound_d = 1'b0;
        end else if (dur_tc) begin
          done_d  = oh(own_q);
          gnt_d   = '0;
          sound_d = 1'b0;
          state_d = S_GAP;
        end else if (half_tc) begin
          sound_d = ~sound_q;
        end
      end
      S_GAP: begin
        gnt_d   = '0;
        sound_d = 1'b0;
        if (gap_tc) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        sound_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    if (RST_i) begin
      state_d = S_IDLE;
      own_d   = '0;
      ack_d   = '0;
      done_d  = '0;
      drop_d  = '0;
      gnt_d   = '0;
      sound_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
      sound_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      sound_q <= sound_d;
    end
  end

  assign ACKs_o  = ack_q;
  assign GNTs_o  = gnt_q;
  assign DONEs_o = done_q;
  assign DROPs_o = drop_q;
  assign BUSY_o  = busy_q;
  assign SOUND_o = sound_q;

endmodule

// File: tb/tb_planet_emp_snd_arb.sv
// Directed bench for the sound arbiter with an event scoreboard.
// Small tone table: HALF={4,3,2}, DUR={40,30,20}, GAP=5.
module tb_planet_emp_snd_arb;

  logic       CK_i = 1'b0;
  logic       XARST_i;
  logic       EE_i;
  logic       RST_i;
  logic [2:0] REQs_i;
  logic [2:0] ACKs_o;
  logic [2:0] GNTs_o;
  logic [2:0] DONEs_o;
  logic [2:0] DROPs_o;
  logic       BUSY_o;
  logic       SOUND_o;

  planet_emp_snd_arb #(
    .C_REQ_N   (3),
    .C_HALF_W  (12),
    .C_DUR_W   (22),
    .C_HALF_Ns ({12'd4, 12'd3, 12'd2}),
    .C_DUR_Ns  ({22'd40, 22'd30, 22'd20}),
    .C_GAP_N   (5)
  ) dut (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .EE_i    (EE_i),
    .RST_i   (RST_i),
    .REQs_i  (REQs_i),
    .ACKs_o  (ACKs_o),
    .GNTs_o  (GNTs_o),
    .DONEs_o (DONEs_o),
    .DROPs_o (DROPs_o),
    .BUSY_o  (BUSY_o),
    .SOUND_o (SOUND_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct packed {
    logic [15:0] cyc;
    logic [2:0]  ack;
    logic [2:0]  done;
    logic [2:0]  drop;
  } evt_t;

  evt_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a;
  int b;
  int p;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic exp_evt(input int c,
                         input logic [2:0] ak,
                         input logic [2:0] dn,
                         input logic [2:0] dp);
    evt_t e;
    e.cyc  = 16'(c);
    e.ack  = ak;
    e.done = dn;
    e.drop = dp;
    sbq.push_back(e);
  endtask

  // One clock; any pulse is matched against the scoreboard head.
  task automatic step();
    evt_t e;
    @(posedge CK_i);
    cyc++;
    #1;
    if ((ACKs_o | DONEs_o | DROPs_o) != 3'b000) begin
      if (sbq.size() == 0) begin
        chk("sb_unexp",
            32'({ACKs_o, DONEs_o, DROPs_o}), 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_evt",
            32'({16'(cyc), ACKs_o, DONEs_o, DROPs_o}),
            32'(e));
      end
    end
    while (sbq.size() != 0 && int'(sbq[0].cyc) < cyc) begin
      e = sbq.pop_front();
      chk("sb_miss", 32'(cyc - 1), 32'(e.cyc));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk_tone(input int a0, input int half,
                          input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 32'(SOUND_o),
          32'(((cyc - a0) / half) % 2));
    end
  endtask

  task automatic step_sparse(input int a0);
    step();
    EE_i = (((cyc + 1 - a0) % 4) == 0);
  endtask

  initial begin
    XARST_i = 1'b0;
    RST_i   = 1'b0;
    EE_i    = 1'b1;
    REQs_i  = 3'b000;
    run(3);
    chk("rst_out", 32'({ACKs_o, GNTs_o, DONEs_o,
                        DROPs_o, BUSY_o, SOUND_o}), 32'd0);
    @(negedge CK_i);
    XARST_i = 1'b1;
    run(2);

    // single request from requester 0
    REQs_i = 3'b001;
    exp_evt(cyc + 1, 3'b001, 3'b000, 3'b000);
    exp_evt(cyc + 21, 3'b000, 3'b001, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b000;
    chk("t1_gnt", 32'(GNTs_o), 32'(3'b001));
    chk("t1_busy", 32'(BUSY_o), 32'd1);
    chk("t1_snd0", 32'(SOUND_o), 32'd0);
    chk_tone(a, 2, 19, "t1_snd");
    step();
    chk("t1_done_snd", 32'(SOUND_o), 32'd0);
    chk("t1_done_gnt", 32'(GNTs_o), 32'd0);
    chk("t1_done_busy", 32'(BUSY_o), 32'd1);
    run(4);
    chk("t1_gap_busy", 32'(BUSY_o), 32'd1);
    step();
    chk("t1_idle", 32'(BUSY_o), 32'd0);

    // simultaneous requests 1 and 0
    REQs_i = 3'b011;
    exp_evt(cyc + 1, 3'b010, 3'b000, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b001;
    exp_evt(a + 30, 3'b000, 3'b010, 3'b000);
    exp_evt(a + 36, 3'b001, 3'b000, 3'b000);
    chk("t2_gnt1", 32'(GNTs_o), 32'(3'b010));
    run(35);
    chk("t2_gap_end", 32'(BUSY_o), 32'd0);
    step();
    REQs_i = 3'b000;
    chk("t2_gnt0", 32'(GNTs_o), 32'(3'b001));
    exp_evt(a + 56, 3'b000, 3'b001, 3'b000);
    run(25);
    chk("t2_idle", 32'(BUSY_o), 32'd0);

    // lower request arriving during PLAY
    REQs_i = 3'b010;
    exp_evt(cyc + 1, 3'b010, 3'b000, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b000;
    run(4);
    REQs_i = 3'b001;
    exp_evt(a + 30, 3'b000, 3'b010, 3'b000);
    exp_evt(a + 36, 3'b001, 3'b000, 3'b000);
    run(a + 36 - cyc);
    REQs_i = 3'b000;
    chk("t4_gnt0", 32'(GNTs_o), 32'(3'b001));
    exp_evt(a + 56, 3'b000, 3'b001, 3'b000);
    run(25);
    chk("t4_idle", 32'(BUSY_o), 32'd0);

    // preemption of requester 0 by requester 2
    REQs_i = 3'b001;
    exp_evt(cyc + 1, 3'b001, 3'b000, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b000;
    chk_tone(a, 2, 8, "t3_snd");
    step();
    REQs_i = 3'b100;
    exp_evt(a + 10, 3'b100, 3'b000, 3'b001);
    exp_evt(a + 50, 3'b000, 3'b100, 3'b000);
    step();
    REQs_i = 3'b000;
    chk("t3_pre_snd", 32'(SOUND_o), 32'd0);
    chk("t3_pre_gnt", 32'(GNTs_o), 32'(3'b100));
    chk("t3_pre_busy", 32'(BUSY_o), 32'd1);
    p = cyc;
    chk_tone(p, 4, 39, "t3_snd2");
    step();
    run(5);
    chk("t3_idle", 32'(BUSY_o), 32'd0);

    // synchronous reset in the middle of a tone
    REQs_i = 3'b100;
    exp_evt(cyc + 1, 3'b100, 3'b000, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b000;
    run(6);
    chk("t5_snd_pre", 32'(SOUND_o), 32'd1);
    RST_i  = 1'b1;
    REQs_i = 3'b010;
    step();
    chk("t5_rst_out", 32'({ACKs_o, GNTs_o, DONEs_o,
                           DROPs_o, BUSY_o, SOUND_o}), 32'd0);
    RST_i = 1'b0;
    exp_evt(cyc + 1, 3'b010, 3'b000, 3'b000);
    step();
    b = cyc;
    REQs_i = 3'b000;
    chk("t5_gnt1", 32'(GNTs_o), 32'(3'b010));
    exp_evt(b + 30, 3'b000, 3'b010, 3'b000);
    run(35);
    chk("t5_idle", 32'(BUSY_o), 32'd0);

    // sparse tick: EE_i every 4th cycle
    REQs_i = 3'b001;
    exp_evt(cyc + 1, 3'b001, 3'b000, 3'b000);
    step();
    a = cyc;
    REQs_i = 3'b000;
    EE_i = 1'b0;
    exp_evt(a + 80, 3'b000, 3'b001, 3'b000);
    for (int i = 0; i < 79; i++) begin
      step_sparse(a);
      chk("t6_snd", 32'(SOUND_o),
          32'(((cyc - a) / 8) % 2));
    end
    step_sparse(a);
    chk("t6_done_snd", 32'(SOUND_o), 32'd0);
    for (int i = 0; i < 19; i++) begin
      step_sparse(a);
    end
    chk("t6_gap_busy", 32'(BUSY_o), 32'd1);
    step_sparse(a);
    chk("t6_idle", 32'(BUSY_o), 32'd0);
    EE_i = 1'b1;
    run(2);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
